// File: rtl/banked_main_mem_if.sv
// Request/response bundle between the cache controller (master) and the banked main memory (slave).
interface banked_main_mem_if;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic        wr;
  logic        rd;
  logic [15:0] data_out;
  logic        rd_valid;
  logic        stall;
  logic [3:0]  busy;
  logic        err;

  modport master (
    output addr, data_in, wr, rd,
    input  data_out, rd_valid, stall, busy, err
  );

  modport slave (
    input  addr, data_in, wr, rd,
    output data_out, rd_valid, stall, busy, err
  );
endinterface

// File: rtl/banked_main_mem.sv
// Four-bank word memory interleaved on addr[2:1]; per-bank occupancy counters
// and a fixed-latency registered read pipeline.
module banked_main_mem #(
  parameter int unsigned BANK_CYCLES    = 4,
  parameter int unsigned READ_LAT       = 2,
  parameter int unsigned WORDS_PER_BANK = 8192
) (
  input logic              clk,
  input logic              rst,
  banked_main_mem_if.slave bus
);

  localparam int unsigned CW    = (BANK_CYCLES > 1) ? $clog2(BANK_CYCLES) : 1;
  localparam int unsigned ROW_W = $clog2(WORDS_PER_BANK);

  logic [15:0]      r_mem [4][WORDS_PER_BANK];
  logic [CW-1:0]    r_cnt [4];
  logic             r_pv  [READ_LAT];
  logic [15:0]      r_pd  [READ_LAT];

  logic             w_req;
  logic [1:0]       w_bank;
  logic [ROW_W-1:0] w_row;
  logic             w_err;
  logic [3:0]       w_busy;
  logic             w_stall;
  logic             w_accept;
  logic             w_acc_rd;
  logic             w_acc_wr;

  assign w_req    = bus.rd | bus.wr;
  assign w_bank   = bus.addr[2:1];
  assign w_row    = bus.addr[ROW_W+2:3];
  assign w_err    = w_req & (bus.addr[0] | (bus.rd & bus.wr));

  always_comb begin
    w_busy = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      w_busy[i] = (r_cnt[i] != '0);
    end
  end

  assign w_stall  = w_req & ~w_err & w_busy[w_bank];
  assign w_accept = w_req & ~w_err & ~w_busy[w_bank];
  assign w_acc_rd = w_accept & bus.rd;
  assign w_acc_wr = w_accept & bus.wr;

  // Accept reloads the target bank; every other non-zero counter just drains.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 4; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_accept && (w_bank == 2'(i))) begin
          r_cnt[i] <= CW'(BANK_CYCLES - 1);
        end else if (r_cnt[i] != '0) begin
          r_cnt[i] <= r_cnt[i] - CW'(1);
        end
      end
    end
  end

  // Array is never cleared; reset only blocks new writes.
  always_ff @(posedge clk) begin
    if (rst && w_acc_wr) begin
      r_mem[w_bank][w_row] <= bus.data_in;
    end
  end

  // Data stages carry zero when their valid is low, so data_out idles at 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < READ_LAT; i++) begin
        r_pv[i] <= 1'b0;
        r_pd[i] <= '0;
      end
    end else begin
      r_pv[0] <= w_acc_rd;
      r_pd[0] <= w_acc_rd ? r_mem[w_bank][w_row] : '0;
      for (int unsigned i = 1; i < READ_LAT; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pd[i] <= r_pd[i-1];
      end
    end
  end

  assign bus.data_out = r_pd[READ_LAT-1];
  assign bus.rd_valid = r_pv[READ_LAT-1];
  assign bus.stall    = w_stall;
  assign bus.busy     = w_busy;
  assign bus.err      = w_err;

endmodule
